// File: rtl/booth_mult_ctrl.sv
// Sequential radix-2 Booth multiplier: control FSM plus the datapath that computes the next value
// of an external (2*WIDTH+1)-bit product register {acc, mplier, booth_bit}.
//
// The register is read back on product_q every cycle. The module reports the low WIDTH bits of
// the product, and a signed-overflow flag, during a one-cycle result-valid pulse.
//
// Ports:
//   clk             rising-edge clock
//   ctrl_reset_n    asynchronous active-low reset
//   ctrl_MULT       start pulse; operands are captured only in this cycle
//   data_operandA   signed multiplicand
//   data_operandB   signed multiplier
//   product_q       current product register contents
//   product_d       next product register value (0 whenever product_we is low)
//   product_we      product register write enable
//   busy            operation in progress (load cycle and shift cycles)
//   data_result     low WIDTH bits of the product, 0 unless data_resultRDY
//   data_exception  product does not fit in WIDTH signed bits, 0 unless data_resultRDY
//   data_resultRDY  one-cycle result-valid pulse
module booth_mult_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             ctrl_reset_n,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic [2*WIDTH:0] product_q,
  output logic [2*WIDTH:0] product_d,
  output logic             product_we,
  output logic             busy,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCount = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] count_q, count_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;

  // Booth step datapath. Accumulator and multiplicand are widened by one sign bit so that
  // acc - mcand cannot overflow even for mcand = -2^(WIDTH-1).
  logic [WIDTH:0]   acc_ext;
  logic [WIDTH:0]   mcand_ext;
  logic [WIDTH:0]   sum;
  logic [2*WIDTH:0] shift_val;
  logic             overflow;

  assign acc_ext   = {product_q[2*WIDTH], product_q[2*WIDTH:WIDTH+1]};
  assign mcand_ext = {mcand_q[WIDTH-1], mcand_q};

  always_comb begin
    sum = acc_ext;
    case (product_q[1:0])
      2'b01:   sum = acc_ext + mcand_ext;
      2'b10:   sum = acc_ext - mcand_ext;
      default: sum = acc_ext;
    endcase
  end

  // Arithmetic right shift of {sum, mplier, booth_bit}: the old booth bit falls off the end.
  assign shift_val = {sum, product_q[WIDTH:1]};

  // Upper half must be a pure sign extension of the low result for the product to fit.
  assign overflow = (product_q[2*WIDTH:WIDTH+1] != {WIDTH{product_q[WIDTH]}});

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    mcand_d        = mcand_q;
    product_d      = '0;
    product_we     = 1'b0;
    busy           = 1'b0;
    data_result    = '0;
    data_exception = 1'b0;
    data_resultRDY = 1'b0;

    case (state_q)
      StIdle: begin
      end
      StShift: begin
        busy       = 1'b1;
        product_d  = shift_val;
        product_we = 1'b1;
        count_d    = count_q + 1'b1;
        if (count_q == LastCount) begin
          state_d = StDone;
        end
      end
      StDone: begin
        data_resultRDY = 1'b1;
        data_result    = product_q[WIDTH:1];
        data_exception = overflow;
        state_d        = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A start pulse wins in every state; in SHIFT it silently abandons the running operation.
    if (ctrl_MULT) begin
      mcand_d    = data_operandA;
      product_d  = {{WIDTH{1'b0}}, data_operandB, 1'b0};
      product_we = 1'b1;
      busy       = 1'b1;
      count_d    = '0;
      state_d    = StShift;
    end

    // Keep the register write path quiet while reset is held, even if ctrl_MULT is high.
    if (!ctrl_reset_n) begin
      product_d  = '0;
      product_we = 1'b0;
      busy       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state_q <= StIdle;
      count_q <= '0;
      mcand_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      mcand_q <= mcand_d;
    end
  end

endmodule

// File: tb/tb_booth_mult_ctrl.sv
module tb_booth_mult_ctrl;

  logic        clk;
  logic        ctrl_reset_n;
  logic        ctrl_MULT;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [64:0] product_q;
  logic [64:0] product_d;
  logic        product_we;
  logic        busy;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int checks = 0;
  int errors = 0;

  booth_mult_ctrl #(.WIDTH(32)) dut (
    .clk            (clk),
    .ctrl_reset_n   (ctrl_reset_n),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .product_q      (product_q),
    .product_d      (product_d),
    .product_we     (product_we),
    .busy           (busy),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  // Product register downstream of the DUT; its own reset is tied inactive.
  always_ff @(posedge clk) begin
    if (product_we) product_q <= product_d;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        exc;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: full signed product with plain arithmetic.
  task automatic ref_mul(input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic exc);
    logic signed [63:0] p;
    logic signed [63:0] lo_ext;
    p      = 64'(signed'(a)) * 64'(signed'(b));
    res    = p[31:0];
    lo_ext = 64'(signed'(res));
    exc    = (p != lo_ext);
  endtask

  // Called just after the edge where ctrl_MULT was raised. Counts edges to the result pulse.
  task automatic wait_rdy(output int lat, output logic [31:0] res, output logic exc);
    lat = 0;
    res = '0;
    exc = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) begin
        ctrl_MULT     = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        check("busy_in_shift", busy, 1);
      end
      if (data_resultRDY) begin
        lat = n;
        res = data_result;
        exc = data_exception;
        break;
      end
    end
    check("rdy_latency", lat, 33);
    if (lat != 0) begin
      @(posedge clk);
      #1;
      check("rdy_one_cycle", data_resultRDY, 0);
      check("idle_result_zero", {data_result, data_exception}, 0);
    end
  endtask

  task automatic drive_start(input logic [31:0] a, input logic [31:0] b);
    ctrl_MULT     = 1'b1;
    data_operandA = a;
    data_operandB = b;
  endtask

  task automatic do_op(input string name, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input logic exp_exc);
    int          lat;
    logic [31:0] res;
    logic        exc;
    drive_start(a, b);
    wait_rdy(lat, res, exc);
    check({name, "_result"}, res, exp_res);
    check({name, "_exception"}, exc, exp_exc);
  endtask

  initial begin
    int          lat;
    int          hits;
    logic [31:0] res;
    logic        exc;
    logic [31:0] ra, rb, er;
    logic        ee;

    vecs[0] = '{32'd3,        32'd5,        32'd15,        1'b0};
    vecs[1] = '{32'hFFFFFFF9, 32'd6,        32'hFFFFFFD6,  1'b0};
    vecs[2] = '{32'd0,        32'h7FFFFFFF, 32'd0,         1'b0};
    vecs[3] = '{32'h80000000, 32'hFFFFFFFF, 32'h80000000,  1'b1};
    vecs[4] = '{32'h80000000, 32'd1,        32'h80000000,  1'b0};
    vecs[5] = '{32'h80000000, 32'h80000000, 32'd0,         1'b1};
    vecs[6] = '{32'd65536,    32'd65536,    32'd0,         1'b1};
    vecs[7] = '{32'd46341,    32'd46340,    32'h7FFF5D14,  1'b0};
    vecs[8] = '{32'd46340,    32'd46340,    32'h7FFEA810,  1'b0};
    vecs[9] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,         1'b0};

    ctrl_reset_n  = 1'b0;
    ctrl_MULT     = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    #1;
    check("reset_outputs",
          {product_d, product_we, busy, data_result, data_exception, data_resultRDY}, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    ctrl_reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_outputs", {product_we, busy, data_result, data_exception, data_resultRDY}, 0);

    // Directed table.
    foreach (vecs[i]) begin
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].exc);
    end

    // Restart mid-SHIFT: the aborted 100*100 must never produce a pulse.
    drive_start(32'd100, 32'd100);
    hits = 0;
    for (int n = 1; n <= 11; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) ctrl_MULT = 1'b0;
      if (data_resultRDY) hits++;
    end
    drive_start(32'd2, 32'd3);
    wait_rdy(lat, res, exc);
    check("abort_no_rdy", hits, 0);
    check("restart_result", {res, exc}, {32'd6, 1'b0});

    // Reset in the middle of SHIFT.
    drive_start(32'd7, 32'd9);
    for (int n = 1; n <= 21; n++) begin
      @(posedge clk);
      #1;
      if (n == 1) ctrl_MULT = 1'b0;
    end
    #3;
    ctrl_reset_n = 1'b0;
    #1;
    check("async_reset_outputs",
          {product_d, product_we, busy, data_result, data_exception, data_resultRDY}, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    ctrl_reset_n = 1'b1;
    hits = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (data_resultRDY || product_we) hits++;
    end
    check("post_reset_quiet", hits, 0);
    do_op("after_reset", 32'd7, 32'd9, 32'd63, 1'b0);

    // Randomised operands checked against the arithmetic reference.
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 3))
        0: begin ra = $urandom; rb = $urandom; end
        1: begin ra = 32'($signed(16'($urandom))); rb = 32'($signed(16'($urandom))); end
        2: begin ra = $urandom_range(0, 1) ? 32'h80000000 : 32'h7FFFFFFF; rb = $urandom; end
        default: begin ra = $urandom_range(0, 70000); rb = $urandom_range(0, 70000); end
      endcase
      ref_mul(ra, rb, er, ee);
      do_op($sformatf("rand%0d", k), ra, rb, er, ee);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
